// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter with an internal prescaler-generated step tick.
// Clear beats load beats step; count wraps between 00 and MAX_VALUE.
module bcd_tick_counter #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_VALUE = 99
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic       Up,
  input  logic       Clr,
  input  logic       Load,
  input  logic [7:0] LoadVal,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Tick,
  output logic       Wrap,
  output logic       LoadErr
);

  localparam logic [25:0] DIV_LAST = 26'(TICK_DIV - 1);
  localparam logic [3:0]  MAX_T    = 4'(MAX_VALUE / 10);
  localparam logic [3:0]  MAX_O    = 4'(MAX_VALUE % 10);

  logic [25:0] presc_q, presc_d;
  logic [3:0]  tens_q, tens_d, ones_q, ones_d;
  logic        tick_q, tick_d, wrap_q, wrap_d, lerr_q, lerr_d;
  logic        step, at_max, at_zero, load_ok;
  logic [3:0]  lt, lo;

  assign lt = LoadVal[7:4];
  assign lo = LoadVal[3:0];

  always_comb begin
    step    = En && (presc_q == DIV_LAST);
    at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
    at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    load_ok = (lt <= 4'd9) && (lo <= 4'd9) &&
              ((lt < MAX_T) || ((lt == MAX_T) && (lo <= MAX_O)));

    presc_d = presc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;

    if (En) presc_d = step ? 26'd0 : presc_q + 26'd1;

    if (Clr) begin
      presc_d = 26'd0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else if (Load) begin
      // A rejected load still restarts the period.
      presc_d = 26'd0;
      if (load_ok) begin
        tens_d = lt;
        ones_d = lo;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (step) begin
      tick_d = 1'b1;
      if (Up) begin
        if (at_max) begin
          tens_d = 4'd0;
          ones_d = 4'd0;
          wrap_d = 1'b1;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          tens_d = MAX_T;
          ones_d = MAX_O;
          wrap_d = 1'b1;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      presc_q <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign Tens    = tens_q;
  assign Ones    = ones_q;
  assign Tick    = tick_q;
  assign Wrap    = wrap_q;
  assign LoadErr = lerr_q;

endmodule
